// File: rtl/mov_xfer_fsm.sv
// Two-phase MOV controller: source read into a hold register, then destination write, repeated for block moves.
// Optional build macro MOV_IO_WAIT_EN: I/O operands wait on io_ready before capturing/advancing.
module mov_xfer_fsm #(
  parameter int DATA_W   = 8,
  parameter int PARAM_W  = 6,
  parameter int NUM_REGS = 32,
  parameter int NUM_IO   = 4,
  parameter int CNT_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                FSM_start,
  input  logic [PARAM_W-1:0]  param1,
  input  logic [PARAM_W-1:0]  param2,
  input  logic [CNT_W-1:0]    count,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   bus_out,
  output logic                hold_bus_out_en,
  output logic                p1isReg,
  output logic                p1isIO,
  output logic                p2isReg,
  output logic                p2isIO,
  output logic                bus_register_out_en,
  output logic                bus_register_input_en,
  output logic [PARAM_W-1:0]  register_addr,
  output logic [NUM_IO-1:0]   io_bus_output_en,
  output logic [NUM_IO-1:0]   io_bus_input_en,
  input  logic [NUM_IO-1:0]   io_ready,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [PARAM_W:0]   LP_REG_LIM  = (PARAM_W+1)'(NUM_REGS);
  localparam logic [PARAM_W:0]   LP_IO_LIM   = (PARAM_W+1)'(NUM_REGS + NUM_IO);
  localparam logic [PARAM_W-1:0] LP_REG_LAST = PARAM_W'(NUM_REGS - 1);
  localparam logic [PARAM_W-1:0] LP_IO_BASE  = PARAM_W'(NUM_REGS);

  function automatic logic code_is_reg(input logic [PARAM_W-1:0] code);
    return ({1'b0, code} < LP_REG_LIM);
  endfunction

  function automatic logic code_is_io(input logic [PARAM_W-1:0] code);
    return (!code_is_reg(code)) && ({1'b0, code} < LP_IO_LIM);
  endfunction

  function automatic logic [PARAM_W-1:0] next_reg_addr(input logic [PARAM_W-1:0] addr);
    return (addr == LP_REG_LAST) ? '0 : addr + PARAM_W'(1);
  endfunction

  function automatic logic [NUM_IO-1:0] io_onehot(input logic [PARAM_W-1:0] code);
    logic [PARAM_W-1:0] idx;
    idx = code - LP_IO_BASE;
    return NUM_IO'(1) << idx;
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic [PARAM_W-1:0]  r_dst;
  logic [PARAM_W-1:0]  r_src;
  logic [CNT_W-1:0]    r_remaining;
  logic [DATA_W-1:0]   r_hold;
  logic                r_p1_reg;
  logic                r_p1_io;
  logic                r_p2_reg;
  logic                r_p2_io;
  logic                w_src_ready;
  logic                w_dst_ready;
  logic                w_operands_ok;

  assign w_operands_ok = (code_is_reg(r_dst) || code_is_io(r_dst)) &&
                         (code_is_reg(r_src) || code_is_io(r_src));

`ifdef MOV_IO_WAIT_EN
  assign w_src_ready = !r_p2_io || ((io_ready & io_onehot(r_src)) != '0);
  assign w_dst_ready = !r_p1_io || ((io_ready & io_onehot(r_dst)) != '0);
`else
  logic w_unused_io_ready;
  assign w_unused_io_ready = ^io_ready;
  assign w_src_ready = 1'b1;
  assign w_dst_ready = 1'b1;
`endif

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (FSM_start) w_next = S_DECODE; else w_next = S_IDLE;
      S_DECODE: if (w_operands_ok) w_next = S_READ; else w_next = S_ERR;
      S_READ:   if (w_src_ready) w_next = S_WRITE; else w_next = S_READ;
      S_WRITE: begin
        if (!w_dst_ready)                     w_next = S_WRITE;
        else if (r_remaining == CNT_W'(1))    w_next = S_DONE;
        else                                  w_next = S_READ;
      end
      S_DONE:   w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State, operand, count and hold registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dst       <= '0;
      r_src       <= '0;
      r_remaining <= '0;
      r_hold      <= '0;
      r_p1_reg    <= 1'b0;
      r_p1_io     <= 1'b0;
      r_p2_reg    <= 1'b0;
      r_p2_io     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (FSM_start) begin
            r_dst       <= param1;
            r_src       <= param2;
            r_remaining <= (count == CNT_W'(0)) ? CNT_W'(1) : count;
          end
        end
        S_DECODE: begin
          r_p1_reg <= code_is_reg(r_dst);
          r_p1_io  <= code_is_io(r_dst);
          r_p2_reg <= code_is_reg(r_src);
          r_p2_io  <= code_is_io(r_src);
        end
        S_READ: begin
          if (w_src_ready) r_hold <= bus_in;
        end
        S_WRITE: begin
          if (w_dst_ready) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_p1_reg) r_dst <= next_reg_addr(r_dst);
            if (r_p2_reg) r_src <= next_reg_addr(r_src);
          end
        end
        S_DONE, S_ERR: begin
          r_p1_reg <= 1'b0;
          r_p1_io  <= 1'b0;
          r_p2_reg <= 1'b0;
          r_p2_io  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state; only one bus driver per state
  always_comb begin
    bus_out               = '0;
    hold_bus_out_en       = 1'b0;
    bus_register_out_en   = 1'b0;
    bus_register_input_en = 1'b0;
    register_addr         = '0;
    io_bus_output_en      = '0;
    io_bus_input_en       = '0;
    done                  = 1'b0;
    error                 = 1'b0;
    case (r_state)
      S_READ: begin
        if (r_p2_reg) begin
          bus_register_out_en = 1'b1;
          register_addr       = r_src;
        end else if (r_p2_io) begin
          io_bus_output_en = io_onehot(r_src);
        end else begin
          io_bus_output_en = '0;
        end
      end
      S_WRITE: begin
        hold_bus_out_en = 1'b1;
        bus_out         = r_hold;
        if (r_p1_reg) begin
          bus_register_input_en = 1'b1;
          register_addr         = r_dst;
        end else if (r_p1_io) begin
          io_bus_input_en = io_onehot(r_dst);
        end else begin
          io_bus_input_en = '0;
        end
      end
      S_DONE: done = 1'b1;
      S_ERR: begin
        done  = 1'b1;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign p1isReg = r_p1_reg;
  assign p1isIO  = r_p1_io;
  assign p2isReg = r_p2_reg;
  assign p2isIO  = r_p2_io;

endmodule

// File: tb/tb_mov_xfer_fsm.sv
// Directed self-checking bench for mov_xfer_fsm with a small register-file / I/O port model on the bus.
module tb_mov_xfer_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic        FSM_start;
  logic [5:0]  param1, param2;
  logic [3:0]  count;
  logic [7:0]  bus_in, bus_out;
  logic        hold_bus_out_en, p1isReg, p1isIO, p2isReg, p2isIO;
  logic        bus_register_out_en, bus_register_input_en;
  logic [5:0]  register_addr;
  logic [3:0]  io_bus_output_en, io_bus_input_en, io_ready;
  logic        busy, done, error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mov_xfer_fsm dut (
    .clock(clock), .reset(reset), .FSM_start(FSM_start),
    .param1(param1), .param2(param2), .count(count),
    .bus_in(bus_in), .bus_out(bus_out), .hold_bus_out_en(hold_bus_out_en),
    .p1isReg(p1isReg), .p1isIO(p1isIO), .p2isReg(p2isReg), .p2isIO(p2isIO),
    .bus_register_out_en(bus_register_out_en), .bus_register_input_en(bus_register_input_en),
    .register_addr(register_addr), .io_bus_output_en(io_bus_output_en),
    .io_bus_input_en(io_bus_input_en), .io_ready(io_ready),
    .busy(busy), .done(done), .error(error)
  );

  // Bus environment: register file and I/O ports
  logic [7:0] rf [0:63];
  logic [7:0] io_src_val [0:3];
  logic [7:0] io_sink_val [0:3];
  logic       clr, pre_en;
  logic [5:0] pre_addr;
  logic [7:0] pre_data;

  always @* begin
    bus_in = 8'h00;
    if (bus_register_out_en) bus_in = rf[register_addr];
    for (int k = 0; k < 4; k++) if (io_bus_output_en[k]) bus_in = io_src_val[k];
  end

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) rf[i] <= 8'h00;
      for (int i = 0; i < 4; i++) io_sink_val[i] <= 8'h00;
    end else begin
      if (pre_en) rf[pre_addr] <= pre_data;
      if (bus_register_input_en) rf[register_addr] <= bus_out;
      for (int k = 0; k < 4; k++) if (io_bus_input_en[k]) io_sink_val[k] <= bus_out;
    end
  end

  // Per-cycle trace, cycle 1 = first cycle after the start edge
  logic [5:0] t_addr [0:39];
  logic       t_rin [0:39], t_rout [0:39], t_hold [0:39], t_p2io [0:39];
  logic [3:0] t_ioo [0:39], t_ioi [0:39];
  logic [7:0] t_bus [0:39];
  int         done_cyc, max_drv;
  logic       done_err, any_en, post_busy, post_done;

  task automatic preset(input logic [5:0] a, input logic [7:0] d);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic launch(input logic [5:0] p1, input logic [5:0] p2, input logic [3:0] cnt);
    @(negedge clock);
    param1 = p1; param2 = p2; count = cnt; FSM_start = 1'b1;
    @(posedge clock);
    #1 FSM_start = 1'b0;
  endtask

  task automatic trace(input int pulse_from, input int pulse_to, input int ready_release);
    int drv;
    done_cyc = -1; max_drv = 0; any_en = 1'b0; done_err = 1'b0;
    post_busy = 1'b1; post_done = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      t_addr[c] = register_addr; t_rin[c] = bus_register_input_en;
      t_rout[c] = bus_register_out_en; t_hold[c] = hold_bus_out_en;
      t_ioo[c] = io_bus_output_en; t_ioi[c] = io_bus_input_en;
      t_bus[c] = bus_out; t_p2io[c] = p2isIO;
      drv = int'(bus_register_out_en) + int'(hold_bus_out_en) + $countones(io_bus_output_en);
      if (drv > max_drv) max_drv = drv;
      if (bus_register_out_en || bus_register_input_en || hold_bus_out_en ||
          io_bus_output_en != 4'h0 || io_bus_input_en != 4'h0) any_en = 1'b1;
      if (c >= pulse_from && c < pulse_to) begin
        FSM_start = 1'b1; param1 = 6'd9; param2 = 6'd40;
      end else begin
        FSM_start = 1'b0;
      end
      if (c == ready_release) io_ready = 4'hF;
      if (done_cyc > 0) begin
        post_busy = busy; post_done = done;
        break;
      end else if (done === 1'b1) begin
        done_cyc = c; done_err = error;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; clr = 1'b1; pre_en = 1'b0; pre_addr = 6'd0; pre_data = 8'h00;
    FSM_start = 1'b0; param1 = 6'd0; param2 = 6'd0; count = 4'd0; io_ready = 4'hF;
    for (int i = 0; i < 4; i++) io_src_val[i] = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, done, error, hold_bus_out_en, bus_register_out_en, bus_register_input_en,
         io_bus_output_en, io_bus_input_en, p1isReg, p1isIO, p2isReg, p2isIO,
         register_addr, bus_out} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b addr=%h bus_out=%h required all zero",
               busy, done, register_addr, bus_out);
    end
    reset = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reg_to_reg;
    preset(6'd2, 8'hA5);
    launch(6'd1, 6'd2, 4'd1);
    trace(0, 0, 0);
    checks++;
    if (t_rout[2] !== 1'b1 || t_addr[2] !== 6'd2) begin
      errors++; $display("FAIL r2r_read: rout=%b addr=%0d required 1/2", t_rout[2], t_addr[2]);
    end
    checks++;
    if ({t_rin[3], t_hold[3], t_addr[3], t_bus[3]} !== {1'b1, 1'b1, 6'd1, 8'hA5}) begin
      errors++; $display("FAIL r2r_write: rin=%b hold=%b addr=%0d bus=%h required 1/1/1/a5",
                         t_rin[3], t_hold[3], t_addr[3], t_bus[3]);
    end
    checks++;
    if (done_cyc != 4 || done_err !== 1'b0) begin
      errors++; $display("FAIL r2r_done: cycle=%0d err=%b required 4/0", done_cyc, done_err);
    end
    checks++;
    if (rf[1] !== 8'hA5 || post_busy !== 1'b0) begin
      errors++; $display("FAIL r2r_result: rf1=%h busy=%b required a5/0", rf[1], post_busy);
    end
  endtask

  task automatic test_io;
    io_src_val[1] = 8'h3C;
    launch(6'd3, 6'd33, 4'd1);
    trace(0, 0, 0);
    checks++;
    if (t_ioo[2] !== 4'b0010 || t_p2io[2] !== 1'b1 || t_rout[2] !== 1'b0) begin
      errors++; $display("FAIL io_read: ioo=%b p2io=%b rout=%b required 0010/1/0",
                         t_ioo[2], t_p2io[2], t_rout[2]);
    end
    checks++;
    if (done_cyc != 4 || rf[3] !== 8'h3C) begin
      errors++; $display("FAIL io_to_reg: done=%0d rf3=%h required 4/3c", done_cyc, rf[3]);
    end
    launch(6'd34, 6'd3, 4'd1);
    trace(0, 0, 0);
    checks++;
    if (t_ioi[3] !== 4'b0100 || t_rin[3] !== 1'b0 || io_sink_val[2] !== 8'h3C) begin
      errors++; $display("FAIL reg_to_io: ioi=%b rin=%b sink2=%h required 0100/0/3c",
                         t_ioi[3], t_rin[3], io_sink_val[2]);
    end
  endtask

  task automatic test_block_wrap;
    preset(6'd5, 8'h11); preset(6'd6, 8'h22); preset(6'd7, 8'h33);
    launch(6'd30, 6'd5, 4'd3);
    trace(0, 0, 0);
    checks++;
    if ({t_addr[2], t_addr[4], t_addr[6]} !== {6'd5, 6'd6, 6'd7}) begin
      errors++; $display("FAIL block_reads: %0d %0d %0d required 5 6 7", t_addr[2], t_addr[4], t_addr[6]);
    end
    checks++;
    if ({t_addr[3], t_addr[5], t_addr[7]} !== {6'd30, 6'd31, 6'd0}) begin
      errors++; $display("FAIL block_writes: %0d %0d %0d required 30 31 0", t_addr[3], t_addr[5], t_addr[7]);
    end
    checks++;
    if (done_cyc != 8 || {rf[30], rf[31], rf[0]} !== 24'h112233) begin
      errors++; $display("FAIL block_result: done=%0d data=%h %h %h required 8 11 22 33",
                         done_cyc, rf[30], rf[31], rf[0]);
    end
    checks++;
    if (max_drv != 1) begin
      errors++; $display("FAIL single_driver: max drivers=%0d required 1", max_drv);
    end
  endtask

  task automatic test_invalid;
    launch(6'd3, 6'd40, 4'd1);
    trace(0, 0, 0);
    checks++;
    if (done_cyc != 2 || done_err !== 1'b1) begin
      errors++; $display("FAIL invalid_done: cycle=%0d err=%b required 2/1", done_cyc, done_err);
    end
    checks++;
    if (any_en !== 1'b0 || post_busy !== 1'b0) begin
      errors++; $display("FAIL invalid_quiet: any_enable=%b busy=%b required 0/0", any_en, post_busy);
    end
  endtask

  task automatic test_reset_abort;
    int dcount;
    preset(6'd10, 8'h71); preset(6'd11, 8'h72); preset(6'd12, 8'h73);
    launch(6'd20, 6'd10, 4'd3);
    repeat (5) @(negedge clock);
    checks++;
    if (bus_register_input_en !== 1'b1 || register_addr !== 6'd21) begin
      errors++; $display("FAIL abort_setup: rin=%b addr=%0d required 1/21", bus_register_input_en, register_addr);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, error, hold_bus_out_en, bus_register_out_en, bus_register_input_en,
         io_bus_output_en, io_bus_input_en, p1isReg, p1isIO, p2isReg, p2isIO,
         register_addr, bus_out} !== 34'h0) begin
      errors++; $display("FAIL abort_outputs: busy=%b done=%b rin=%b addr=%0d required all zero",
                         busy, done, bus_register_input_en, register_addr);
    end
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0 || rf[20] !== 8'h71 || rf[22] !== 8'h00) begin
      errors++; $display("FAIL abort_quiet: activity=%0d rf20=%h rf22=%h required 0/71/00",
                         dcount, rf[20], rf[22]);
    end
    launch(6'd25, 6'd10, 4'd1);
    trace(0, 0, 0);
    checks++;
    if (done_cyc != 4 || rf[25] !== 8'h71) begin
      errors++; $display("FAIL abort_restart: done=%0d rf25=%h required 4/71", done_cyc, rf[25]);
    end
  endtask

  task automatic test_count_zero_busy_start;
    preset(6'd2, 8'h5E);
    launch(6'd8, 6'd2, 4'd0);
    trace(1, 3, 0);
    checks++;
    if (done_cyc != 4 || done_err !== 1'b0 || rf[8] !== 8'h5E) begin
      errors++; $display("FAIL count_zero: done=%0d err=%b rf8=%h required 4/0/5e", done_cyc, done_err, rf[8]);
    end
    checks++;
    if (post_busy !== 1'b0 || post_done !== 1'b0) begin
      errors++; $display("FAIL busy_start_ignored: busy=%b done=%b required 0/0", post_busy, post_done);
    end
  endtask

  task automatic test_io_wait;
    int exp_done;
    logic [3:0] exp_ioo4;
`ifdef MOV_IO_WAIT_EN
    exp_done = 7; exp_ioo4 = 4'b0010;
`else
    exp_done = 4; exp_ioo4 = 4'b0000;
`endif
    io_src_val[1] = 8'h5A;
    io_ready = 4'b1101;
    launch(6'd4, 6'd33, 4'd1);
    trace(0, 0, 5);
    checks++;
    if (done_cyc != exp_done || t_ioo[4] !== exp_ioo4) begin
      errors++; $display("FAIL io_wait: done=%0d ioo4=%b required %0d/%b", done_cyc, t_ioo[4], exp_done, exp_ioo4);
    end
    checks++;
    if (rf[4] !== 8'h5A) begin
      errors++; $display("FAIL io_wait_data: rf4=%h required 5a", rf[4]);
    end
    io_ready = 4'hF;
  endtask

  initial begin
    test_reset();
    test_reg_to_reg();
    test_io();
    test_block_wrap();
    test_invalid();
    test_reset_abort();
    test_count_zero_busy_start();
    test_io_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mov_xfer_fsm.md
Name: mov_xfer_fsm

Overview:
Parametrised successor to the single-move MOV controller.
- Moves data between register-file entries and NUM_IO I/O ports over the shared single-driver bus.
- Uses an internal hold register, so every transfer is two phases: a source read, then a destination write.
- Adds block moves: a count operand, with register addresses auto-incrementing and wrapping.
- Flags invalid operand codes with an error.
- Sits in the control unit alongside the other instruction FSMs, started by the decoder via FSM_start.

Parameters:
DATA_W, 8, bus/data width
PARAM_W, 6, operand code width (also register_addr width)
NUM_REGS, 32, register-file entries; codes 0..NUM_REGS-1 select registers
NUM_IO, 4, I/O ports; codes NUM_REGS..NUM_REGS+NUM_IO-1 select port 0..NUM_IO-1. Constraint: NUM_REGS+NUM_IO <= 2^PARAM_W
CNT_W, 4, width of element count

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
FSM_start  in  1  start request, sampled only in IDLE
param1  in  PARAM_W  destination operand code
param2  in  PARAM_W  source operand code
count  in  CNT_W  elements to move; 0 treated as 1
bus_in  in  DATA_W  shared bus value, captured in READ
bus_out  out  DATA_W  hold register, driven in WRITE
hold_bus_out_en  out  1  FSM drives bus_out onto bus
p1isReg/p1isIO/p2isReg/p2isIO  out  1 each  registered operand class flags
bus_register_out_en  out  1  register file drives bus
bus_register_input_en  out  1  register file latches bus
register_addr  out  PARAM_W  register-file address
io_bus_output_en  out  NUM_IO  one-hot: port drives bus
io_bus_input_en  out  NUM_IO  one-hot: port latches bus
io_ready  in  NUM_IO  port handshake; used only with MOV_IO_WAIT_EN
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
error  out  1  one-cycle pulse with done on invalid operand

Behaviour:
- Reset: state IDLE, hold=0, all outputs 0. A reset mid-operation aborts at that edge; no done pulse; no enables on the following cycle.
- States: IDLE, DECODE, READ, WRITE, DONE, ERR. Outputs are decoded from registered state/registers, so they are glitch-free.
- IDLE: FSM_start=1 at an edge latches param1, param2 and count (0 becomes 1) into remaining, then goes to DECODE. FSM_start is level-sampled, so holding it high re-launches after DONE.
- DECODE (1 cycle): classify each operand.
  - code < NUM_REGS: register.
  - code < NUM_REGS+NUM_IO: I/O port.
  - otherwise: invalid.
  - Any invalid operand goes to ERR; else to READ.
  - Flags are set at this edge and held until IDLE, where they are 0.
- READ: source enable asserted (bus_register_out_en with register_addr=src, or io_bus_output_en[src-NUM_REGS]). hold <= bus_in at the cycle end; go to WRITE.
- WRITE:
  - Assert hold_bus_out_en, with bus_out=hold.
  - Assert the destination enable: bus_register_input_en with register_addr=dst, or io_bus_input_en[k].
  - At the cycle end, remaining decrements. A register src/dst increments modulo NUM_REGS (NUM_REGS-1 wraps to 0); I/O operands do not increment.
  - Go to DONE if remaining was 1, else back to READ.
- DONE: done=1 for one cycle, then IDLE. ERR: done=1 and error=1 for one cycle, then IDLE; no bus enable is ever asserted on an ERR path.
- Latency from the start edge: N elements give done in cycle 2N+2; ERR gives done in cycle 2.
- At most one bus driver asserted per cycle. FSM_start is ignored while busy. Overlapping src/dst ranges are copied element-by-element in ascending order, with no overlap check.

Optional Feature:
MOV_IO_WAIT_EN
- Defined: in READ/WRITE on an I/O operand k, the FSM stays in the state with the enable held until io_ready[k]=1. Capture/advance happens on the cycle io_ready[k] is high. Register operands never wait.
- Undefined: io_ready is ignored and latency is fixed as above.

Test Plan:
1. reset, then param1=1, param2=2, count=1, FSM_start 1 cycle, bus_in=8'hA5 while register_addr==2 -> WRITE cycle shows register_addr=1, bus_register_input_en=1, hold_bus_out_en=1, bus_out=A5; done high exactly cycle 4; error=0.
2. param1=3, param2=33 (IO1) -> READ shows io_bus_output_en=4'b0010, p2isIO=1; register 3 written with bus value; done in cycle 4.
3. param1=30, param2=5, count=3 -> reads addr 5, 6, 7; writes 30, 31, 0 (wrap); done in cycle 8.
4. param2=40 (invalid) -> done=1 and error=1 in cycle 2; no enable ever asserted; busy low afterwards.
5. count=3 block, reset asserted during the second WRITE -> next cycle all outputs 0, no done; a new start then completes normally.
6. count=0 -> behaves as 1 (done cycle 4); FSM_start pulses while busy are ignored. With MOV_IO_WAIT_EN, io_ready[1] held low 3 cycles extends done by 3.
